// File: rtl/branch_predictor_gshare.sv
// Fetch-stage branch prediction unit: gshare direction predictor, tagged
// direct-mapped BTB carrying a branch-type field, and a circular return
// address stack. GHR and RAS are updated speculatively at fetch and are
// repaired from the fetch-time snapshots when EX reports a misprediction.
module branch_predictor_gshare #(
  parameter int PHT_IDX_W = 10,
  parameter int GHR_W     = 10,
  parameter int BTB_IDX_W = 6,
  parameter int RAS_DEPTH = 8,
  localparam int P        = $clog2(RAS_DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       PC,
  input  logic              Fetch_Valid,
  input  logic              BPU__Stall,
  input  logic              Flush__IRQ,
  output logic              Pred_Taken,
  output logic [31:0]       Pred_Target,
  output logic              Pred_Hit,
  output logic [GHR_W-1:0]  Pred_GHR,
  output logic [2*P:0]      Pred_RAS_State,
  input  logic              Res_Valid,
  input  logic [31:0]       Res_PC,
  input  logic [1:0]        Res_Type,
  input  logic              Res_Taken,
  input  logic [31:0]       Res_Target,
  input  logic [GHR_W-1:0]  Res_GHR,
  input  logic [2*P:0]      Res_RAS_State,
  input  logic              Res_Mispredict
);

  localparam int PHT_N = 1 << PHT_IDX_W;
  localparam int BTB_N = 1 << BTB_IDX_W;
  localparam int TAG_W = 30 - BTB_IDX_W;

  typedef enum logic [1:0] {
    BR_COND = 2'b00,
    BR_JUMP = 2'b01,
    BR_CALL = 2'b10,
    BR_RET  = 2'b11
  } br_type_e;

  // Prediction state
  logic [1:0]       pht_q       [PHT_N];
  logic [BTB_N-1:0] btb_valid_q;
  logic [TAG_W-1:0] btb_tag_q   [BTB_N];
  logic [29:0]      btb_tgt_q   [BTB_N];
  br_type_e         btb_type_q  [BTB_N];
  logic [29:0]      ras_q       [RAS_DEPTH];
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic [P-1:0]     ras_ptr_q, ras_ptr_d;
  logic [P:0]       ras_cnt_q, ras_cnt_d;

  // RAS data write port, shared by speculative push and recovery push
  logic             ras_we;
  logic [P-1:0]     ras_waddr;
  logic [29:0]      ras_wdata;

  // History shift that works for any GHR_W >= 1
  function automatic logic [GHR_W-1:0] ghr_shift(input logic [GHR_W-1:0] h,
                                                 input logic b);
    return (h << 1) | GHR_W'(b);
  endfunction

  // ---------------- Fetch-side lookup ----------------
  logic [BTB_IDX_W-1:0] f_btb_idx;
  logic [TAG_W-1:0]     f_tag;
  logic [PHT_IDX_W-1:0] f_pht_idx;
  logic                 f_hit;
  br_type_e             f_type;
  logic [P-1:0]         ras_top_idx;
  logic                 ras_nonempty;
  logic                 raw_taken;
  logic                 spec_en;

  assign f_btb_idx    = PC[BTB_IDX_W+1:2];
  assign f_tag        = PC[31:BTB_IDX_W+2];
  assign f_pht_idx    = PC[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr_q);
  assign f_hit        = btb_valid_q[f_btb_idx] && (btb_tag_q[f_btb_idx] == f_tag);
  assign f_type       = btb_type_q[f_btb_idx];
  assign ras_top_idx  = ras_ptr_q - P'(1);
  assign ras_nonempty = (ras_cnt_q != '0);

  // Direction decision from the stored branch type
  always_comb begin
    raw_taken = 1'b0;
    case (f_type)
      BR_COND: raw_taken = f_hit && pht_q[f_pht_idx][1];
      BR_JUMP,
      BR_CALL: raw_taken = f_hit;
      BR_RET:  raw_taken = f_hit && ras_nonempty;
      default: raw_taken = 1'b0;
    endcase
  end

  assign Pred_Hit       = f_hit;
  assign Pred_Taken     = !RST && !Flush__IRQ && raw_taken;
  assign Pred_Target    = RST ? 32'h0 :
                          {((f_type == BR_RET) ? ras_q[ras_top_idx] : btb_tgt_q[f_btb_idx]), 2'b00};
  assign Pred_GHR       = ghr_q;
  assign Pred_RAS_State = {ras_cnt_q, ras_ptr_q};

  assign spec_en = Fetch_Valid && !BPU__Stall && !Flush__IRQ && f_hit;

  // ---------------- Resolve-side decode ----------------
  logic [BTB_IDX_W-1:0] r_btb_idx;
  logic [TAG_W-1:0]     r_tag;
  logic [PHT_IDX_W-1:0] r_pht_idx;
  logic [P:0]           r_cnt;
  logic [P-1:0]         r_ptr;
  logic                 recover;

  assign r_btb_idx = Res_PC[BTB_IDX_W+1:2];
  assign r_tag     = Res_PC[31:BTB_IDX_W+2];
  assign r_pht_idx = Res_PC[PHT_IDX_W+1:2] ^ PHT_IDX_W'(Res_GHR);
  assign r_cnt     = Res_RAS_State[2*P:P];
  assign r_ptr     = Res_RAS_State[P-1:0];
  assign recover   = Res_Valid && Res_Mispredict;

  // Next GHR/RAS state: recovery first, otherwise speculative fetch update
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    ghr_d     = ghr_q;
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    ras_we    = 1'b0;
    ras_waddr = ras_ptr_q;
    ras_wdata = PC[31:2] + 30'd1;
    if (recover) begin
      ghr_d     = (Res_Type == BR_COND) ? ghr_shift(Res_GHR, Res_Taken) : Res_GHR;
      ras_ptr_d = r_ptr;
      ras_cnt_d = r_cnt;
      if (Res_Type == BR_CALL) begin
        ras_we    = 1'b1;
        ras_waddr = r_ptr;
        ras_wdata = Res_PC[31:2] + 30'd1;
        ras_ptr_d = r_ptr + P'(1);
        ras_cnt_d = (r_cnt == (P+1)'(RAS_DEPTH)) ? r_cnt : r_cnt + (P+1)'(1);
      end else if (Res_Type == BR_RET && r_cnt != '0) begin
        ras_ptr_d = r_ptr - P'(1);
        ras_cnt_d = r_cnt - (P+1)'(1);
      end
    end else if (spec_en) begin
      case (f_type)
        BR_COND: ghr_d = ghr_shift(ghr_q, raw_taken);
        BR_CALL: begin
          ras_we    = 1'b1;
          ras_ptr_d = ras_ptr_q + P'(1);
          ras_cnt_d = (ras_cnt_q == (P+1)'(RAS_DEPTH)) ? ras_cnt_q : ras_cnt_q + (P+1)'(1);
        end
        BR_RET: begin
          if (ras_nonempty) begin
            ras_ptr_d = ras_ptr_q - P'(1);
            ras_cnt_d = ras_cnt_q - (P+1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // GHR and RAS pointer/count registers
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (RST) begin
      ghr_q     <= '0;
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
    end else begin
      ghr_q     <= ghr_d;
      ras_ptr_q <= ras_ptr_d;
      ras_cnt_q <= ras_cnt_d;
    end
  end

  // Saturating 2-bit counter training on resolved conditional branches
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= 2'b01;
    end else if (Res_Valid && Res_Type == BR_COND) begin
      if (Res_Taken && pht_q[r_pht_idx] != 2'b11)
        pht_q[r_pht_idx] <= pht_q[r_pht_idx] + 2'b01;
      else if (!Res_Taken && pht_q[r_pht_idx] != 2'b00)
        pht_q[r_pht_idx] <= pht_q[r_pht_idx] - 2'b01;
    end
  end

  // BTB valid bits: set on any taken resolve
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      btb_valid_q <= '0;
    end else if (Res_Valid && Res_Taken) begin
      btb_valid_q[r_btb_idx] <= 1'b1;
    end
  end

  // BTB payload: written alongside the valid bit, replaces any occupant
  always_ff @(posedge CLK) begin
    // NOTE: payload arrays carry no reset; the valid bits alone decide whether an entry is used.
    if (Res_Valid && Res_Taken) begin
      btb_tag_q[r_btb_idx]  <= r_tag;
      btb_tgt_q[r_btb_idx]  <= Res_Target[31:2];
      btb_type_q[r_btb_idx] <= br_type_e'(Res_Type);
    end
  end

  // RAS data entries: never restored on recovery
  always_ff @(posedge CLK) begin
    if (ras_we) ras_q[ras_waddr] <= ras_wdata;
  end

  // Word-alignment bits carry no information for this unit
  logic unused_ok;
  assign unused_ok = ^{PC[1:0], Res_PC[1:0], Res_Target[1:0]};

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed self-checking bench for branch_predictor_gshare (default parameters).
module tb_branch_predictor_gshare;

  logic        CLK, RST;
  logic [31:0] PC;
  logic        Fetch_Valid, BPU__Stall, Flush__IRQ;
  logic        Pred_Taken, Pred_Hit;
  logic [31:0] Pred_Target;
  logic [9:0]  Pred_GHR;
  logic [6:0]  Pred_RAS_State;
  logic        Res_Valid, Res_Taken, Res_Mispredict;
  logic [31:0] Res_PC, Res_Target;
  logic [1:0]  Res_Type;
  logic [9:0]  Res_GHR;
  logic [6:0]  Res_RAS_State;

  int checks = 0;
  int errors = 0;

  branch_predictor_gshare dut (
    .CLK(CLK), .RST(RST), .PC(PC), .Fetch_Valid(Fetch_Valid),
    .BPU__Stall(BPU__Stall), .Flush__IRQ(Flush__IRQ),
    .Pred_Taken(Pred_Taken), .Pred_Target(Pred_Target), .Pred_Hit(Pred_Hit),
    .Pred_GHR(Pred_GHR), .Pred_RAS_State(Pred_RAS_State),
    .Res_Valid(Res_Valid), .Res_PC(Res_PC), .Res_Type(Res_Type),
    .Res_Taken(Res_Taken), .Res_Target(Res_Target), .Res_GHR(Res_GHR),
    .Res_RAS_State(Res_RAS_State), .Res_Mispredict(Res_Mispredict)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one clock and land 1 time unit after the rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic [1:0] ty, input logic tk,
                         input logic [31:0] tgt, input logic [9:0] gh,
                         input logic [6:0] rs, input logic mis);
    Res_Valid = 1'b1; Res_PC = pc; Res_Type = ty; Res_Taken = tk;
    Res_Target = tgt; Res_GHR = gh; Res_RAS_State = rs; Res_Mispredict = mis;
  endtask

  task automatic test_reset();
    RST = 1'b1; PC = 32'h100; Fetch_Valid = 1'b1; BPU__Stall = 1'b0; Flush__IRQ = 1'b0;
    Res_Valid = 1'b0; Res_PC = '0; Res_Type = '0; Res_Taken = 1'b0; Res_Target = '0;
    Res_GHR = '0; Res_RAS_State = '0; Res_Mispredict = 1'b0;
    tick(); tick();
    checks++; if (Pred_Taken !== 1'b0) begin errors++; $display("FAIL rst_taken got=%0b want=0", Pred_Taken); end
    checks++; if (Pred_Target !== 32'h0) begin errors++; $display("FAIL rst_target got=%h want=0", Pred_Target); end
    RST = 1'b0;
    #1;
    checks++; if (Pred_Hit !== 1'b0) begin errors++; $display("FAIL rst_hit got=%0b want=0", Pred_Hit); end
    checks++; if (Pred_Taken !== 1'b0) begin errors++; $display("FAIL post_rst_taken got=%0b want=0", Pred_Taken); end
    checks++; if (Pred_GHR !== 10'h0) begin errors++; $display("FAIL rst_ghr got=%h want=0", Pred_GHR); end
    checks++; if (Pred_RAS_State !== 7'h0) begin errors++; $display("FAIL rst_ras got=%h want=0", Pred_RAS_State); end
    Fetch_Valid = 1'b0;
  endtask

  task automatic test_cond_train();
    PC = 32'h100;
    resolve(32'h100, 2'b00, 1'b1, 32'h200, 10'h0, 7'h0, 1'b0);
    tick(); // counter 01 -> 10
    checks++; if (Pred_Hit !== 1'b1) begin errors++; $display("FAIL train_hit got=%0b want=1", Pred_Hit); end
    checks++; if (Pred_Taken !== 1'b1) begin errors++; $display("FAIL train_ctr10 got=%0b want=1", Pred_Taken); end
    tick(); // 10 -> 11
    Res_Valid = 1'b0; Fetch_Valid = 1'b1;
    #1;
    checks++; if (Pred_Taken !== 1'b1) begin errors++; $display("FAIL train_taken got=%0b want=1", Pred_Taken); end
    checks++; if (Pred_Target !== 32'h200) begin errors++; $display("FAIL train_target got=%h want=200", Pred_Target); end
    tick(); // speculative shift of a taken COND
    Fetch_Valid = 1'b0;
    #1;
    checks++; if (Pred_GHR !== 10'h001) begin errors++; $display("FAIL spec_ghr got=%h want=001", Pred_GHR); end
    // index now 0x40^0x001 = 0x41, untouched counter 01
    checks++; if (Pred_Taken !== 1'b0) begin errors++; $display("FAIL ghr_index got=%0b want=0", Pred_Taken); end
  endtask

  task automatic test_saturation();
    resolve(32'h100, 2'b01, 1'b0, 32'h0, 10'h0, 7'h0, 1'b1); // JUMP recovery: GHR <= 0
    tick();
    checks++; if (Pred_GHR !== 10'h0) begin errors++; $display("FAIL jump_recover_ghr got=%h want=0", Pred_GHR); end
    resolve(32'h100, 2'b00, 1'b1, 32'h200, 10'h0, 7'h0, 1'b0);
    tick(); // 11 stays 11
    Res_Taken = 1'b0;
    tick(); // 10
    checks++; if (Pred_Taken !== 1'b1) begin errors++; $display("FAIL sat_top got=%0b want=1", Pred_Taken); end
    tick(); // 01
    checks++; if (Pred_Taken !== 1'b0) begin errors++; $display("FAIL dec_01 got=%0b want=0", Pred_Taken); end
    tick(); tick(); // 00, clamp 00
    checks++; if (Pred_Taken !== 1'b0) begin errors++; $display("FAIL dec_00 got=%0b want=0", Pred_Taken); end
    Res_Taken = 1'b1;
    tick(); // 01
    checks++; if (Pred_Taken !== 1'b0) begin errors++; $display("FAIL sat_bottom got=%0b want=0", Pred_Taken); end
    tick(); // 10
    checks++; if (Pred_Taken !== 1'b1) begin errors++; $display("FAIL inc_10 got=%0b want=1", Pred_Taken); end
    Res_Valid = 1'b0;
  endtask

  task automatic test_ras();
    resolve(32'h300, 2'b10, 1'b1, 32'h400, 10'h0, 7'h0, 1'b0); tick(); // CALL in BTB[0]
    resolve(32'h504, 2'b11, 1'b1, 32'h600, 10'h0, 7'h0, 1'b0); tick(); // RET in BTB[1]
    Res_Valid = 1'b0;
    PC = 32'h504;
    #1;
    checks++; if (Pred_Hit !== 1'b1) begin errors++; $display("FAIL ret_hit got=%0b want=1", Pred_Hit); end
    checks++; if (Pred_Taken !== 1'b0) begin errors++; $display("FAIL ret_empty got=%0b want=0", Pred_Taken); end
    PC = 32'h300; Fetch_Valid = 1'b1;
    #1;
    checks++; if (Pred_Taken !== 1'b1) begin errors++; $display("FAIL call_taken got=%0b want=1", Pred_Taken); end
    checks++; if (Pred_Target !== 32'h400) begin errors++; $display("FAIL call_target got=%h want=400", Pred_Target); end
    repeat (9) tick();
    checks++; if (Pred_RAS_State !== {4'd8, 3'd1}) begin errors++; $display("FAIL ras_full got=%h want=41", Pred_RAS_State); end
    PC = 32'h504;
    #1;
    checks++; if (Pred_Target !== 32'h304) begin errors++; $display("FAIL ret_target got=%h want=304", Pred_Target); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (Pred_Taken !== 1'b1) begin errors++; $display("FAIL pop_%0d got=%0b want=1", i, Pred_Taken); end
      tick();
    end
    checks++; if (Pred_Taken !== 1'b0) begin errors++; $display("FAIL ret_drained got=%0b want=0", Pred_Taken); end
    checks++; if (Pred_RAS_State !== 7'h01) begin errors++; $display("FAIL ras_drained got=%h want=01", Pred_RAS_State); end
    tick(); // pop on empty
    checks++; if (Pred_RAS_State !== 7'h01) begin errors++; $display("FAIL pop_empty got=%h want=01", Pred_RAS_State); end
    Fetch_Valid = 1'b0;
  endtask

  task automatic test_recovery();
    PC = 32'h300; Fetch_Valid = 1'b1;
    tick(); tick();
    Fetch_Valid = 1'b0;
    #1;
    checks++; if (Pred_RAS_State !== 7'h13) begin errors++; $display("FAIL snap_ras got=%h want=13", Pred_RAS_State); end
    Fetch_Valid = 1'b1;
    tick(); tick();
    Fetch_Valid = 1'b0;
    #1;
    checks++; if (Pred_RAS_State !== 7'h25) begin errors++; $display("FAIL spec_push got=%h want=25", Pred_RAS_State); end
    resolve(32'h110, 2'b00, 1'b1, 32'h200, 10'h155, 7'h13, 1'b1);
    tick();
    Res_Valid = 1'b0;
    checks++; if (Pred_RAS_State !== 7'h13) begin errors++; $display("FAIL cond_recover_ras got=%h want=13", Pred_RAS_State); end
    checks++; if (Pred_GHR !== 10'h2AB) begin errors++; $display("FAIL cond_recover_ghr got=%h want=2ab", Pred_GHR); end
  endtask

  task automatic test_back_to_back();
    PC = 32'h300; Fetch_Valid = 1'b1;
    resolve(32'h110, 2'b00, 1'b0, 32'h0, 10'h001, 7'h0D, 1'b1);
    tick();
    Fetch_Valid = 1'b0; Res_Valid = 1'b0;
    checks++; if (Pred_RAS_State !== 7'h0D) begin errors++; $display("FAIL same_cycle_ras got=%h want=0d", Pred_RAS_State); end
    checks++; if (Pred_GHR !== 10'h002) begin errors++; $display("FAIL same_cycle_ghr got=%h want=002", Pred_GHR); end
    resolve(32'h708, 2'b10, 1'b1, 32'h400, 10'h0F0, 7'h0D, 1'b1);
    tick();
    Res_Valid = 1'b0; PC = 32'h504;
    #1;
    checks++; if (Pred_RAS_State !== 7'h16) begin errors++; $display("FAIL call_recover_ras got=%h want=16", Pred_RAS_State); end
    checks++; if (Pred_GHR !== 10'h0F0) begin errors++; $display("FAIL call_recover_ghr got=%h want=0f0", Pred_GHR); end
    checks++; if (Pred_Target !== 32'h70C) begin errors++; $display("FAIL call_recover_top got=%h want=70c", Pred_Target); end
    resolve(32'h504, 2'b11, 1'b1, 32'h600, 10'h3FF, 7'h16, 1'b1);
    tick();
    Res_Valid = 1'b0;
    checks++; if (Pred_RAS_State !== 7'h0D) begin errors++; $display("FAIL ret_recover_ras got=%h want=0d", Pred_RAS_State); end
    checks++; if (Pred_GHR !== 10'h3FF) begin errors++; $display("FAIL ret_recover_ghr got=%h want=3ff", Pred_GHR); end
    checks++; if (Pred_Target !== 32'h304) begin errors++; $display("FAIL ret_recover_top got=%h want=304", Pred_Target); end
  endtask

  task automatic test_flush_stall();
    PC = 32'h300; Fetch_Valid = 1'b1; Flush__IRQ = 1'b1;
    #1;
    checks++; if (Pred_Hit !== 1'b1) begin errors++; $display("FAIL flush_hit got=%0b want=1", Pred_Hit); end
    checks++; if (Pred_Taken !== 1'b0) begin errors++; $display("FAIL flush_taken got=%0b want=0", Pred_Taken); end
    tick();
    checks++; if (Pred_RAS_State !== 7'h0D) begin errors++; $display("FAIL flush_no_push got=%h want=0d", Pred_RAS_State); end
    PC = 32'h110; // COND, counter at 0x3BB is 01
    tick();
    checks++; if (Pred_GHR !== 10'h3FF) begin errors++; $display("FAIL flush_ghr got=%h want=3ff", Pred_GHR); end
    Flush__IRQ = 1'b0; BPU__Stall = 1'b1; PC = 32'h300;
    #1;
    checks++; if (Pred_Taken !== 1'b1) begin errors++; $display("FAIL stall_pred got=%0b want=1", Pred_Taken); end
    resolve(32'h100, 2'b01, 1'b0, 32'h0, 10'h0AA, 7'h0D, 1'b1);
    tick();
    Res_Valid = 1'b0;
    checks++; if (Pred_RAS_State !== 7'h0D) begin errors++; $display("FAIL stall_no_push got=%h want=0d", Pred_RAS_State); end
    checks++; if (Pred_GHR !== 10'h0AA) begin errors++; $display("FAIL stall_resolve got=%h want=0aa", Pred_GHR); end
    BPU__Stall = 1'b0; PC = 32'h110; // counter at 0x44^0x0AA = 0xEE is 01
    tick();
    Fetch_Valid = 1'b0;
    checks++; if (Pred_GHR !== 10'h154) begin errors++; $display("FAIL spec_not_taken got=%h want=154", Pred_GHR); end
  endtask

  task automatic test_mid_reset();
    PC = 32'h300; Fetch_Valid = 1'b1;
    #2;
    RST = 1'b1;
    #1;
    checks++; if (Pred_GHR !== 10'h0) begin errors++; $display("FAIL async_rst_ghr got=%h want=0", Pred_GHR); end
    checks++; if (Pred_RAS_State !== 7'h0) begin errors++; $display("FAIL async_rst_ras got=%h want=0", Pred_RAS_State); end
    checks++; if (Pred_Taken !== 1'b0) begin errors++; $display("FAIL async_rst_taken got=%0b want=0", Pred_Taken); end
    checks++; if (Pred_Target !== 32'h0) begin errors++; $display("FAIL async_rst_target got=%h want=0", Pred_Target); end
    RST = 1'b0;
    #1;
    checks++; if (Pred_Hit !== 1'b0) begin errors++; $display("FAIL async_rst_btb got=%0b want=0", Pred_Hit); end
    Fetch_Valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cond_train();
    test_saturation();
    test_ras();
    test_recovery();
    test_back_to_back();
    test_flush_stall();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor_gshare.md
Name: branch_predictor_gshare

Overview:
- Parametrised next-generation branch prediction unit for the fetch stage. Combines a gshare direction predictor, a tagged direct-mapped BTB with a branch-type field, and a circular return address stack.
- Unlike the previous unit, counter saturation, GHR speculation and GHR/RAS misprediction recovery are handled inside the block. EX supplies only resolved outcomes plus the snapshots this block emitted at fetch.

Parameters:
- PHT_IDX_W, 10, log2 of PHT entries (2-bit counters).
- GHR_W, 10, global history length; must be <= PHT_IDX_W.
- BTB_IDX_W, 6, log2 of BTB entries.
- RAS_DEPTH, 8, RAS entries; power of 2, >= 2. P = log2(RAS_DEPTH).

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; asynchronous, active-high.
- PC  in  32  fetch PC.
- Fetch_Valid  in  1  PC is a real fetch this cycle.
- BPU__Stall  in  1  freeze all speculative state.
- Flush__IRQ  in  1  suppress prediction and speculative updates.
- Pred_Taken  out  1  predicted redirect.
- Pred_Target  out  32  predicted target, bits [1:0] = 0.
- Pred_Hit  out  1  BTB hit.
- Pred_GHR  out  GHR_W  GHR snapshot, carried down the pipe.
- Pred_RAS_State  out  2P+1  {count[P:0], ptr[P-1:0]} snapshot.
- Res_Valid  in  1  EX resolved a control-transfer instruction.
- Res_PC  in  32  its PC.
- Res_Type  in  2  00 COND, 01 JUMP, 10 CALL, 11 RET.
- Res_Taken  in  1  actual direction.
- Res_Target  in  32  actual target.
- Res_GHR  in  GHR_W  its fetch-time Pred_GHR.
- Res_RAS_State  in  2P+1  its fetch-time Pred_RAS_State.
- Res_Mispredict  in  1  direction or target was wrong; qualified by Res_Valid.

Behaviour:
Reset:
- PHT = 2'b01 everywhere, all BTB valid bits = 0, GHR = 0, RAS ptr = 0, RAS count = 0.
- While RST is high, Pred_Taken = 0 and Pred_Target = 0.
- RST asserted mid-operation clears state immediately.

Lookup (combinational, same cycle):
- BTB index = PC[BTB_IDX_W+1:2]; tag = PC[31:BTB_IDX_W+2]; hit = valid & tag match.
- PHT index = PC[PHT_IDX_W+1:2] XOR zero-extended GHR.
- Pred_Taken by type:
  - COND: hit & ctr[1].
  - JUMP and CALL: hit.
  - RET: hit & (count != 0).
- Pred_Target = RAS[ptr-1] for RET, otherwise the BTB target.
- Pred_Taken is forced to 0 when Flush__IRQ = 1.
- Pred_GHR and Pred_RAS_State always show the current registers.

Speculative update (clock edge):
- Enabled when Fetch_Valid & !BPU__Stall & !Flush__IRQ & hit.
- COND: GHR <= {GHR[GHR_W-2:0], Pred_Taken}.
- CALL: RAS[ptr] <= PC+4; ptr++ (wraps); count saturates at RAS_DEPTH. When full, the push overwrites the oldest entry.
- RET with count != 0: ptr--, count--. Pop on empty is a no-op.

Resolve (clock edge, Res_Valid = 1, independent of the stall):
- COND: PHT[Res_PC idx XOR Res_GHR] saturating update. +1 if Res_Taken, -1 otherwise; clamps at 3 and 0.
- Res_Taken: write BTB entry {valid = 1, tag, Res_Target[31:2], Res_Type}, replacing any occupant.

Recovery (clock edge, Res_Valid & Res_Mispredict):
- GHR <= {Res_GHR[GHR_W-2:0], Res_Taken} for COND, Res_GHR otherwise.
- RAS state <= Res_RAS_State, then the resolved CALL (push Res_PC+4) or RET (pop) is applied to the restored state.
- Recovery has priority over the fetch-side speculative update in the same cycle, which is discarded.
- RAS data entries are not restored; overwritten entries stay overwritten.

Hazards:
- Same-cycle read and write of a PHT or BTB entry: the read returns the old value. No bypass.
- A non-mispredicted resolve never touches GHR or RAS.

Test Plan:
- Reset, then PC=0x100 with Fetch_Valid -> Pred_Hit=0, Pred_Taken=0, Pred_GHR=0.
- Resolve COND at 0x100, Taken=1, Target=0x200, Res_GHR=0, twice -> counter 01→10→11. Next fetch of 0x100 with GHR=0 -> Pred_Taken=1, Pred_Target=0x200. After that speculative update, GHR=0x001.
- Three Taken=0 resolves at the same index -> counter clamps at 00 and does not wrap; predict not-taken.
- CALL at 0x300 (BTB target 0x400) fetched 9 times with RAS_DEPTH=8 -> count stays 8. RET hit -> Pred_Target=0x304, and 8 pops then empty -> Pred_Taken=0 for RET.
- Snapshot taken with count=2, then 2 speculative pushes, then a mispredicted COND resolve carrying that snapshot -> count back to 2; GHR = {Res_GHR<<1 | Res_Taken}.
- Same-cycle Fetch hit on a CALL with Res_Mispredict -> RAS equals the restored state, no push. Flush__IRQ=1 on a BTB hit -> Pred_Taken=0 and GHR unchanged.
